neur_mult_responder: RTL and testbench

//  Responder side of the neural multiply interface: accepts 4 operand-lane pairs from
//  the neural control unit, computes a mode-dependent signed sum of products and returns
//  it as mult_prod/mult_valid. Sits between the neural control unit and the register

---
 rtl/neur_pkg.sv | 29 ++
 rtl/neur_lane_mult.sv | 33 +++
 rtl/neur_mult_responder.sv | 110 +++++++++++
 tb/tb_neur_mult_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/neur_pkg.sv
// Shared types, constants and sign-extension helpers for the neural multiply interface.
package neur_pkg;

    typedef enum logic [1:0] {
        NM_INT16  = 2'b00,
        NM_INT8X2 = 2'b01,
        NM_INT4X4 = 2'b10,
        NM_RSVD   = 2'b11
    } neur_mode_e;

    localparam int NEUR_LANES    = 4;
    localparam int NEUR_MULT_LAT = 2;
    localparam int NEUR_OPER_W   = 16;
    localparam int NEUR_LANE_W   = 32;

    // Sign-extend packed sub-operands to the lane product width.
    function automatic logic signed [NEUR_LANE_W-1:0] sext4(input logic [3:0] v);
        return {{(NEUR_LANE_W-4){v[3]}}, v};
    endfunction

    function automatic logic signed [NEUR_LANE_W-1:0] sext8(input logic [7:0] v);
        return {{(NEUR_LANE_W-8){v[7]}}, v};
    endfunction

    function automatic logic signed [NEUR_LANE_W-1:0] sext16(input logic [15:0] v);
        return {{(NEUR_LANE_W-16){v[15]}}, v};
    endfunction

endpackage

// File: rtl/neur_lane_mult.sv
// One combinational multiply lane: mode-dependent signed sum of sub-word products.
module neur_lane_mult
    import neur_pkg::*;
(
    input  logic [NEUR_OPER_W-1:0]        a_i,
    input  logic [NEUR_OPER_W-1:0]        b_i,
    input  neur_mode_e                    mode_i,
    output logic signed [NEUR_LANE_W-1:0] prod_o
);

    // Select the operand packing and accumulate the sub-word products.
    always_comb begin
        prod_o = '0;
        case (mode_i)
            NM_INT16: begin
                prod_o = sext16(a_i) * sext16(b_i);
            end
            NM_INT8X2: begin
                prod_o = sext8(a_i[15:8]) * sext8(b_i[15:8])
                       + sext8(a_i[7:0])  * sext8(b_i[7:0]);
            end
            NM_INT4X4: begin
                for (int n = 0; n < 4; n++) begin
                    prod_o = prod_o + sext4(a_i[4*n +: 4]) * sext4(b_i[4*n +: 4]);
                end
            end
            default: begin
                prod_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/neur_mult_responder.sv
// Responder for the neural multiply interface: 4-lane signed sum of products,
// fixed two-cycle pipeline, one issue per cycle, no backpressure.
module neur_mult_responder
    import neur_pkg::*;
#(
    parameter int LANES = NEUR_LANES,
    parameter int OUT_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   neur_mult_en,
    input  logic [1:0]             neur_mode,
    input  logic [NEUR_OPER_W-1:0] mult_oper_a0,
    input  logic [NEUR_OPER_W-1:0] mult_oper_a1,
    input  logic [NEUR_OPER_W-1:0] mult_oper_a2,
    input  logic [NEUR_OPER_W-1:0] mult_oper_a3,
    input  logic [NEUR_OPER_W-1:0] mult_oper_b0,
    input  logic [NEUR_OPER_W-1:0] mult_oper_b1,
    input  logic [NEUR_OPER_W-1:0] mult_oper_b2,
    input  logic [NEUR_OPER_W-1:0] mult_oper_b3,
    input  logic                   flush_i,
    output logic [OUT_W-1:0]       mult_prod,
    output logic                   mult_valid
);

    logic [NEUR_OPER_W-1:0]        opa_d     [LANES];
    logic [NEUR_OPER_W-1:0]        opb_d     [LANES];
    logic [NEUR_OPER_W-1:0]        opa_p0_q  [LANES];
    logic [NEUR_OPER_W-1:0]        opb_p0_q  [LANES];
    neur_mode_e                    mode_p0_q;
    logic                          vld_p0_q;
    logic signed [NEUR_LANE_W-1:0] lane_prod_d [LANES];
    logic signed [NEUR_LANE_W-1:0] prod_p1_q   [LANES];
    logic                          vld_p1_q;
    logic signed [OUT_W-1:0]       sum_d;
    logic signed [OUT_W-1:0]       mult_prod_q;
    logic                          mult_valid_q;

    assign opa_d[0] = mult_oper_a0;
    assign opa_d[1] = mult_oper_a1;
    assign opa_d[2] = mult_oper_a2;
    assign opa_d[3] = mult_oper_a3;
    assign opb_d[0] = mult_oper_b0;
    assign opb_d[1] = mult_oper_b1;
    assign opb_d[2] = mult_oper_b2;
    assign opb_d[3] = mult_oper_b3;

    // S1: capture operands and mode only on issue, so idle cycles do not toggle the datapath.
    always_ff @(posedge clk_i) begin
        if (neur_mult_en) begin
            for (int k = 0; k < LANES; k++) begin
                opa_p0_q[k] <= opa_d[k];
                opb_p0_q[k] <= opb_d[k];
            end
            mode_p0_q <= neur_mode_e'(neur_mode);
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        neur_lane_mult u_lane (
            .a_i    (opa_p0_q[g]),
            .b_i    (opb_p0_q[g]),
            .mode_i (mode_p0_q),
            .prod_o (lane_prod_d[g])
        );
    end

    // S2: register the lane products of a live S1 op.
    always_ff @(posedge clk_i) begin
        if (vld_p0_q) begin
            for (int k = 0; k < LANES; k++) begin
                prod_p1_q[k] <= lane_prod_d[k];
            end
        end
    end

    // Lane adder; the sum wraps modulo 2^OUT_W.
    always_comb begin
        sum_d = '0;
        for (int k = 0; k < LANES; k++) begin
            sum_d = sum_d + OUT_W'(prod_p1_q[k]);
        end
    end

    // Output stage: reset clears the result, a flush leaves the last result in place.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mult_prod_q <= '0;
        end else if (vld_p1_q && !flush_i) begin
            mult_prod_q <= sum_d;
        end
    end

    // Valid chain travelling with the data; reset or flush kills every op in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            vld_p0_q     <= 1'b0;
            vld_p1_q     <= 1'b0;
            mult_valid_q <= 1'b0;
        end else begin
            vld_p0_q     <= neur_mult_en;
            vld_p1_q     <= vld_p0_q;
            mult_valid_q <= vld_p1_q;
        end
    end

    assign mult_prod  = mult_prod_q;
    assign mult_valid = mult_valid_q;

endmodule

// File: tb/tb_neur_mult_responder.sv
// Bench for neur_mult_responder: vector table plus hand-written flush/reset sequences,
// results checked by a scoreboard of expected value and arrival cycle.
module tb_neur_mult_responder;
    import neur_pkg::*;

    logic        clk = 1'b0;
    logic        rst, en, flush;
    logic [1:0]  mode;
    logic [15:0] a0, a1, a2, a3, b0, b1, b2, b3;
    logic [31:0] prod;
    logic        valid;

    always #5 clk = ~clk;

    neur_mult_responder dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .neur_mult_en (en),
        .neur_mode    (mode),
        .mult_oper_a0 (a0),
        .mult_oper_a1 (a1),
        .mult_oper_a2 (a2),
        .mult_oper_a3 (a3),
        .mult_oper_b0 (b0),
        .mult_oper_b1 (b1),
        .mult_oper_b2 (b2),
        .mult_oper_b3 (b3),
        .flush_i      (flush),
        .mult_prod    (prod),
        .mult_valid   (valid)
    );

    typedef struct packed {
        logic [1:0]       mode;
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        logic [31:0]      exp;
    } vec_t;

    typedef struct packed {
        logic [31:0] prod;
        int unsigned cyc;
    } exp_t;

    localparam int NVEC = 9;
    vec_t        tbl [NVEC];
    exp_t        sbq [$];
    exp_t        e_mon;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;

    function automatic vec_t mk(input logic [1:0] m,
                                input logic [15:0] xa0, xa1, xa2, xa3,
                                input logic [15:0] xb0, xb1, xb2, xb3,
                                input logic [31:0] x);
        vec_t v;
        v.mode = m;
        v.a    = {xa3, xa2, xa1, xa0};
        v.b    = {xb3, xb2, xb1, xb0};
        v.exp  = x;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    // Drive one issue at the current negedge; optionally expect its result.
    task automatic drive(input vec_t v, input bit push);
        en   = 1'b1;
        mode = v.mode;
        a0 = v.a[0]; a1 = v.a[1]; a2 = v.a[2]; a3 = v.a[3];
        b0 = v.b[0]; b1 = v.b[1]; b2 = v.b[2]; b3 = v.b[3];
        if (push) sbq.push_back('{prod: v.exp, cyc: cyc + 1 + NEUR_MULT_LAT});
    endtask

    // Idle cycle with garbage operands that must be ignored.
    task automatic idle();
        en   = 1'b0;
        mode = 2'($urandom);
        a0 = 16'($urandom); a1 = 16'($urandom); a2 = 16'($urandom); a3 = 16'($urandom);
        b0 = 16'($urandom); b1 = 16'($urandom); b2 = 16'($urandom); b3 = 16'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", sbq.size());
            sbq.delete();
        end
    endtask

    // Monitor: sample just after each active edge and match against the scoreboard.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid cyc=%0d prod=%h required no valid", cyc, prod);
            end else begin
                e_mon = sbq.pop_front();
                chk("prod", prod, e_mon.prod);
                chk("latency_cycle", 32'(cyc), 32'(e_mon.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = mk(2'b00, 16'h0003, 16'h0, 16'h0, 16'h0, 16'hFFFE, 16'h0, 16'h0, 16'h0, 32'hFFFFFFFA);
        tbl[1] = mk(2'b01, 16'h0203, 16'h00FF, 16'h0, 16'h0, 16'h0405, 16'h0002, 16'h0, 16'h0, 32'h00000015);
        tbl[2] = mk(2'b10, 16'h1111, 16'h1111, 16'h1111, 16'h1111,
                    16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFFFFF0);
        tbl[3] = mk(2'b11, 16'h1111, 16'h1111, 16'h1111, 16'h1111,
                    16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'h00000000);
        tbl[4] = mk(2'b00, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                    16'h8000, 16'h8000, 16'h8000, 16'h8000, 32'h00000000);
        tbl[5] = mk(2'b00, 16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h7FFF, 16'h0, 16'h0, 16'h0, 32'h3FFF0001);
        tbl[6] = mk(2'b01, 16'h0, 16'h8080, 16'h0, 16'h0, 16'h0, 16'h8080, 16'h0, 16'h0, 32'h00008000);
        tbl[7] = mk(2'b10, 16'h8888, 16'h8888, 16'h8888, 16'h8888,
                    16'h8888, 16'h8888, 16'h8888, 16'h8888, 32'h00000400);
        tbl[8] = mk(2'b10, 16'h0, 16'h0, 16'h7777, 16'h0, 16'h0, 16'h0, 16'h8888, 16'h0, 32'hFFFFFF20);

        rst = 1'b1;
        flush = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_prod", prod, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single INT16 issue: one pulse, exactly at the expected cycle.
        drive(tbl[0], 1'b1);
        @(negedge clk); idle();
        drain();
        repeat (3) @(negedge clk);
        chk("hold_after_single", prod, 32'hFFFFFFFA);

        // Whole table back-to-back, mode changing every cycle.
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i], 1'b1);
            @(negedge clk);
        end
        idle();
        drain();
        chk("hold_after_burst", prod, tbl[NVEC-1].exp);

        // Flush one cycle after issue.
        drive(tbl[1], 1'b0);
        @(negedge clk); idle(); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        repeat (5) @(negedge clk);
        chk("flush_p0_hold", prod, tbl[NVEC-1].exp);

        // Flush in the same cycle as the issue.
        drive(tbl[1], 1'b0); flush = 1'b1;
        @(negedge clk); idle(); flush = 1'b0;
        repeat (5) @(negedge clk);
        chk("flush_same_hold", prod, tbl[NVEC-1].exp);

        // Flush at the edge where the output would load.
        drive(tbl[1], 1'b0);
        @(negedge clk); idle();
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        repeat (5) @(negedge clk);
        chk("flush_p1_hold", prod, tbl[NVEC-1].exp);

        // Pipeline still works after flushes.
        drive(tbl[1], 1'b1);
        @(negedge clk); idle();
        drain();

        // Reset one cycle after issue: no valid, result cleared.
        drive(tbl[0], 1'b0);
        @(negedge clk); idle(); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_inflight_prod", prod, 32'd0);

        // Reset and flush together: reset wins, result cleared.
        drive(tbl[2], 1'b1);
        @(negedge clk); idle();
        drain();
        rst = 1'b1; flush = 1'b1;
        @(negedge clk); rst = 1'b0; flush = 1'b0;
        chk("rst_flush_prod", prod, 32'd0);
        chk("rst_flush_valid", 32'(valid), 32'd0);
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
